// File: rtl/guess_game_ctrl.sv
// -----------------------------------------------------------------------------
// guess_game_ctrl
// Sequential controller around a DATA_W-bit magnitude comparator. It holds the
// secret on the comparator Y input and registers each player guess onto the X
// input, then samples the comparator flags one cycle later to produce hints,
// win/lose status and a bounded count of checked guesses.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   load       pulse: capture secret_in and start a new round (any state)
//   secret_in  secret value
//   submit     pulse: present guess_in (honoured only while ARMED)
//   guess_in   player guess
//   lg/eq/sm   comparator flags: X > Y, X == Y, X < Y
//   x_out      registered guess driven to comparator X
//   y_out      registered secret driven to comparator Y
//   hint_high  last guess too large
//   hint_low   last guess too small
//   win/lose   round outcome, terminal until load or reset
//   tries      completed checked guesses this round
//   busy       high for the single CHECK cycle
//   flag_err   sticky: comparator flags were not one-hot
// -----------------------------------------------------------------------------
module guess_game_ctrl #(
  parameter int DATA_W    = 2,
  parameter int MAX_TRIES = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] secret_in,
  input  logic              submit,
  input  logic [DATA_W-1:0] guess_in,
  input  logic              lg,
  input  logic              eq,
  input  logic              sm,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic              hint_high,
  output logic              hint_low,
  output logic              win,
  output logic              lose,
  output logic [CNT_W-1:0]  tries,
  output logic              busy,
  output logic              flag_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  // True when exactly one of the three comparator flags is asserted.
  function automatic logic flags_onehot(input logic a, input logic b, input logic c);
    return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
  endfunction

  state_t              state_q;
  logic [DATA_W-1:0]   x_q;
  logic [DATA_W-1:0]   y_q;
  logic                hint_high_q;
  logic                hint_low_q;
  logic                win_q;
  logic                lose_q;
  logic [CNT_W-1:0]    tries_q;
  logic                busy_q;
  logic                flag_err_q;

  logic [CNT_W-1:0]    tries_d;
  logic                last_try_s;
  logic                onehot_s;

  // Incremented count and the "this wrong guess ends the round" decision.
  // The compare is an unsigned CNT_W-bit compare against MAX_TRIES.
  assign tries_d    = tries_q + CNT_W'(1'b1);
  assign last_try_s = (tries_d == CNT_W'(MAX_TRIES));
  assign onehot_s   = flags_onehot(lg, eq, sm);

  // Round FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      tries_q     <= '0;
      busy_q      <= 1'b0;
      flag_err_q  <= 1'b0;
    end else if (load) begin
      // load wins over submit and aborts a CHECK in flight; x_q keeps its value.
      state_q     <= ARMED;
      y_q         <= secret_in;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      tries_q     <= '0;
      busy_q      <= 1'b0;
      flag_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (submit) begin
            x_q     <= guess_in;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        CHECK: begin
          // Comparator has settled on the x_q registered one edge earlier.
          busy_q <= 1'b0;
          if (!onehot_s) begin
            flag_err_q  <= 1'b1;
            hint_high_q <= 1'b0;
            hint_low_q  <= 1'b0;
            state_q     <= ARMED;
          end else if (eq) begin
            win_q       <= 1'b1;
            hint_high_q <= 1'b0;
            hint_low_q  <= 1'b0;
            tries_q     <= tries_d;
            state_q     <= WIN;
          end else begin
            hint_high_q <= lg;
            hint_low_q  <= sm;
            tries_q     <= tries_d;
            if (last_try_s) begin
              lose_q  <= 1'b1;
              state_q <= LOSE;
            end else begin
              state_q <= ARMED;
            end
          end
        end
        IDLE, WIN, LOSE: begin
          // Waiting for load; submit is ignored and everything holds.
          busy_q <= 1'b0;
        end
        default: begin
          // Unreachable encodings recover to a safe idle state.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign hint_high = hint_high_q;
  assign hint_low  = hint_low_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign tries     = tries_q;
  assign busy      = busy_q;
  assign flag_err  = flag_err_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed testbench for guess_game_ctrl with a behavioural comparator that
// can be overridden to inject illegal flag combinations.
module tb_guess_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [1:0] secret_in;
  logic       submit;
  logic [1:0] guess_in;
  logic       lg, eq, sm;
  logic [1:0] x_out, y_out;
  logic       hint_high, hint_low, win, lose, busy, flag_err;
  logic [2:0] tries;

  logic       ovr, ovr_lg, ovr_eq, ovr_sm;

  int checks;
  int failures;

  guess_game_ctrl #(.DATA_W(2), .MAX_TRIES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .secret_in(secret_in),
    .submit(submit), .guess_in(guess_in), .lg(lg), .eq(eq), .sm(sm),
    .x_out(x_out), .y_out(y_out), .hint_high(hint_high), .hint_low(hint_low),
    .win(win), .lose(lose), .tries(tries), .busy(busy), .flag_err(flag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model fed from the DUT's own X/Y outputs, with an override.
  always_comb begin
    lg = 1'b0;
    eq = 1'b0;
    sm = 1'b0;
    if (ovr) begin
      lg = ovr_lg;
      eq = ovr_eq;
      sm = ovr_sm;
    end else begin
      lg = (x_out > y_out);
      eq = (x_out == y_out);
      sm = (x_out < y_out);
    end
  end

  // Packed view of every output: {x,y,hh,hl,win,lose,tries,busy,flag_err}.
  logic [12:0] outs;
  assign outs = {x_out, y_out, hint_high, hint_low, win, lose, tries, busy, flag_err};

  function automatic logic [12:0] pack(input logic [1:0] x, input logic [1:0] y,
                                       input logic hh, input logic hl,
                                       input logic w, input logic l,
                                       input logic [2:0] t, input logic b,
                                       input logic fe);
    return {x, y, hh, hl, w, l, t, b, fe};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] s);
    load = 1'b1;
    secret_in = s;
    step();
    load = 1'b0;
  endtask

  // Submit a guess and let the CHECK cycle complete (two edges).
  task automatic do_guess(input logic [1:0] g);
    submit = 1'b1;
    guess_in = g;
    step();
    submit = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    load = 1'b0;
    submit = 1'b0;
    secret_in = 2'd0;
    guess_in = 2'd0;
    ovr = 1'b0;
    ovr_lg = 1'b0;
    ovr_eq = 1'b0;
    ovr_sm = 1'b0;

    #12;
    check("reset_outs", outs, pack(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    step();

    // Submit before any load is ignored.
    do_guess(2'd3);
    check("idle_submit", outs, pack(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));

    // Basic round: secret 2, guess 3 -> hint_high.
    do_load(2'd2);
    check("load2", outs, pack(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    submit = 1'b1;
    guess_in = 2'd3;
    step();
    submit = 1'b0;
    check("check_busy", outs, pack(2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
    step();
    check("hint_high", outs, pack(2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0));

    // Secret 1: guesses 0, 3, 1 -> low, high, win.
    do_load(2'd1);
    check("load1", outs, pack(2'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    do_guess(2'd0);
    check("g0_low", outs, pack(2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0));
    do_guess(2'd3);
    check("g3_high", outs, pack(2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0));
    do_guess(2'd1);
    check("g1_win", outs, pack(2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0));
    do_guess(2'd2);
    check("win_hold", outs, pack(2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0));

    // Secret 0: four wrong guesses -> lose, fifth ignored.
    do_load(2'd0);
    do_guess(2'd1);
    do_guess(2'd2);
    do_guess(2'd3);
    check("three_wrong", outs, pack(2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0));
    do_guess(2'd1);
    check("lose", outs, pack(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0));
    do_guess(2'd2);
    check("lose_hold", outs, pack(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0));

    // load + submit together: load wins, no CHECK.
    do_load(2'd3);
    do_guess(2'd0);
    check("pre_both", outs, pack(2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0));
    load = 1'b1;
    submit = 1'b1;
    secret_in = 2'd2;
    guess_in = 2'd3;
    step();
    load = 1'b0;
    submit = 1'b0;
    check("load_submit", outs, pack(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    step();
    check("no_check", outs, pack(2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));

    // load during CHECK aborts the check (guess 1 < 2 would set hint_low).
    submit = 1'b1;
    guess_in = 2'd1;
    step();
    submit = 1'b0;
    check("abort_busy", outs, pack(2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
    do_load(2'd1);
    check("abort", outs, pack(2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    step();
    check("abort_idle", outs, pack(2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    do_guess(2'd1);
    check("abort_armed", outs, pack(2'd1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0));

    // Illegal comparator flags -> flag_err, tries unchanged, still playable.
    do_load(2'd2);
    ovr = 1'b1;
    ovr_lg = 1'b1;
    ovr_eq = 1'b1;
    ovr_sm = 1'b0;
    do_guess(2'd2);
    ovr = 1'b0;
    check("flag_err", outs, pack(2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    do_guess(2'd2);
    check("err_win", outs, pack(2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1));
    do_load(2'd0);
    check("err_clear", outs, pack(2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));

    // All-zero flags are also illegal.
    ovr = 1'b1;
    ovr_lg = 1'b0;
    ovr_eq = 1'b0;
    ovr_sm = 1'b0;
    do_guess(2'd3);
    ovr = 1'b0;
    check("flag_zero", outs, pack(2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));

    // Asynchronous reset in the middle of CHECK.
    do_load(2'd1);
    submit = 1'b1;
    guess_in = 2'd0;
    step();
    submit = 1'b0;
    check("pre_reset", outs, pack(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, pack(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_guess(2'd3);
    check("post_reset", outs, pack(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Sequential controller wrapped around the 2-bit magnitude comparator (X/Y in, LG/EQ/SM out).
- Holds a secret value on the comparator's Y input and registers each player guess onto its X input.
- Samples the comparator flags and drives hint, win and lose outputs with a bounded attempt counter.
- Acts as both the stage upstream of the comparator (feeds X/Y) and the stage downstream of it (consumes LG/EQ/SM).

Parameters:
- DATA_W, 2, width of secret/guess/comparator operands.
- MAX_TRIES, 4, number of wrong guesses that ends the round in LOSE (legal range 1..7).
- CNT_W, 3, width of the tries counter (must hold MAX_TRIES).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle pulse: capture secret_in, start a new round.
- secret_in  in  DATA_W  secret value.
- submit  in  1  one-cycle pulse: present guess_in.
- guess_in  in  DATA_W  player guess.
- lg  in  1  comparator: X > Y.
- eq  in  1  comparator: X == Y.
- sm  in  1  comparator: X < Y.
- x_out  out  DATA_W  registered guess driven to comparator X.
- y_out  out  DATA_W  registered secret driven to comparator Y.
- hint_high  out  1  last guess too large.
- hint_low  out  1  last guess too small.
- win  out  1  round won.
- lose  out  1  round lost.
- tries  out  CNT_W  completed checked guesses this round.
- busy  out  1  high in CHECK.
- flag_err  out  1  sticky: comparator flags not one-hot.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs and registers go to 0; state = IDLE.
  - Reset takes effect immediately, including mid-CHECK; no partial update survives.
- States: IDLE, ARMED, CHECK, WIN, LOSE.
- load (honoured in every state):
  - At the edge: y_out <= secret_in; tries, hint_high, hint_low, win, lose, flag_err <= 0; state <= ARMED.
  - x_out is unchanged.
  - load during CHECK aborts the check; no flag sampling and no tries update.
- load and submit in the same cycle: load wins, submit is dropped.
- submit:
  - Honoured only in ARMED: x_out <= guess_in, state <= CHECK.
  - Ignored in IDLE, CHECK, WIN and LOSE; no state or output change.
- CHECK (exactly one cycle; the comparator has settled on the new x_out):
  - Sample lg/eq/sm at the CHECK-exit edge.
  - If the flags are not exactly one-hot:
    - flag_err <= 1; hints cleared; tries unchanged; state <= ARMED.
  - If eq:
    - win <= 1; hints cleared; tries <= tries+1; state <= WIN.
  - If lg or sm:
    - hint_high <= lg; hint_low <= sm; tries <= tries+1.
    - If tries+1 == MAX_TRIES: lose <= 1, state <= LOSE; else state <= ARMED.
- Latency: submit sampled at edge N; x_out updates at N; results and tries are visible after edge N+1. busy is high for the cycle between those edges.
- WIN and LOSE are terminal until load or reset. Outputs hold; tries never exceeds MAX_TRIES (no wrap).
- hint_high and hint_low are never both 1. win and lose are never both 1.
- flag_err stays set until load or reset and does not block play.
- Width rules:
  - tries compare is an unsigned CNT_W-bit compare.
  - x_out/y_out are plain DATA_W registers; no arithmetic on them.

Test Plan:
- Reset then load=1, secret_in=2 -> y_out=2, state ARMED, all flags 0. Submit guess 3 with comparator lg=1 -> x_out=3 at next edge, busy=1 for one cycle, then hint_high=1, tries=1.
- Secret 1; guesses 0, 3, 1 (comparator model driven from x_out/y_out) -> hint_low, then hint_high, then win=1, tries=3. A further submit leaves all outputs unchanged.
- MAX_TRIES=4, secret 0; guesses 1, 2, 3, 1 -> lose=1 after the 4th check, tries=4. A 5th submit is ignored.
- load and submit asserted in the same cycle while ARMED -> only the secret reloads, tries=0, x_out unchanged, no CHECK entered. Separately, load during CHECK -> tries unchanged, state ARMED.
- Comparator forced lg=1, eq=1 during CHECK -> flag_err=1, tries unchanged, state ARMED. Then a legal eq -> win=1 with flag_err still 1. A subsequent load clears flag_err.
- rst_n pulsed low mid-CHECK (asynchronously, not on an edge) -> all outputs 0 immediately. After release, submit is ignored until the next load.
